multiword_add_ctrl: RTL and testbench

MULTIWORD_ADD_CTRL -- requirements
Module: multiword_add_ctrl

---
 rtl/add_ctrl_pkg.sv | 12 +
 rtl/RCA_8bit.sv | 27 ++
 rtl/multiword_add_ctrl.sv | 122 ++++++++++++
 tb/tb_multiword_add_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/add_ctrl_pkg.sv
// Shared FSM state encoding and byte width for the multiword add controller.
package add_ctrl_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/RCA_8bit.sv
// Purpose: 8-bit ripple-carry adder slice shared by the byte-serial controller.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module RCA_8bit
    import add_ctrl_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              ci,
    output logic [BYTE_W-1:0] s,
    output logic              co
);

    // Carry is a block-local running variable so the chain stays a single comb process.
    logic carry;

    always_comb begin
        carry = ci;
        s     = '0;
        for (int i = 0; i < BYTE_W; i++) begin
            s[i]  = a[i] ^ b[i] ^ carry;
            carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        co = carry;
    end

endmodule

// File: rtl/multiword_add_ctrl.sv
// Purpose: W-bit add/subtract computed one byte per cycle on a single shared 8-bit adder, LSB first.
// Latency: out_valid rises NUM_BYTES cycles after the accepting edge.
// Backpressure: result held in DONE until out_ready; in_ready low from accept until the cycle after consume.
module multiword_add_ctrl
    import add_ctrl_pkg::*;
#(
    parameter  int NUM_BYTES = 4,
    localparam int W         = BYTE_W * NUM_BYTES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    input  logic         c_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         c_out,
    output logic         ovf
);

    localparam int              IDX_W    = $clog2(NUM_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q;
    logic [W-1:0]        a_q, b_q;
    logic                carry_q;
    logic [W-1:0]        sum_q;
    logic                c_out_q, ovf_q;

    logic [BYTE_W-1:0]   a_byte, b_byte, byte_sum;
    logic                byte_co;
    logic                last_byte;

    // Operand byte select on idx.
    always_comb begin
        a_byte = '0;
        b_byte = '0;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                a_byte = a_q[i*BYTE_W +: BYTE_W];
                b_byte = b_q[i*BYTE_W +: BYTE_W];
            end
        end
    end

    RCA_8bit u_rca (
        .a  (a_byte),
        .b  (b_byte),
        .ci (carry_q),
        .s  (byte_sum),
        .co (byte_co)
    );

    assign last_byte = (idx_q == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = RUN;
            end
            RUN: begin
                if (last_byte) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (state_q == IDLE && in_valid) begin
            // Subtract is a + ~b + 1; c_in only matters for add.
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= sub | c_in;
            idx_q   <= '0;
        end else if (state_q == RUN) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (idx_q == IDX_W'(i)) sum_q[i*BYTE_W +: BYTE_W] <= byte_sum;
            end
            carry_q <= byte_co;
            idx_q   <= idx_q + IDX_W'(1);
            if (last_byte) begin
                c_out_q <= byte_co;
                // Carry into the MSB recovered from the MSB sum bit and its operands.
                ovf_q   <= a_q[W-1] ^ b_q[W-1] ^ byte_sum[BYTE_W-1] ^ byte_co;
            end
        end
    end

    assign sum   = sum_q;
    assign c_out = c_out_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_multiword_add_ctrl.sv
// Directed-vector bench for multiword_add_ctrl with a queue scoreboard and independent output monitor.
module tb_multiword_add_ctrl;

    localparam int NB = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a, b;
    logic        sub, c_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        c_out, ovf;

    typedef struct {
        logic [31:0] s;
        logic        c;
        logic        o;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   total = 0;
    int   bad   = 0;
    int   got_n = 0;

    multiword_add_ctrl #(.NUM_BYTES(NB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h @%0t", nm, got, want, $time);
        end
    endtask

    // Monitor: one comparison set per completed output handshake.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result got sum=%0h want=no result", sum);
            end else begin
                e = q.pop_front();
                chk("sum", 64'(sum), 64'(e.s));
                chk("c_out", 64'(c_out), 64'(e.c));
                chk("ovf", 64'(ovf), 64'(e.o));
                got_n++;
            end
        end
    end

    task automatic scramble();
        a    = $urandom;
        b    = $urandom;
        sub  = 1'($urandom);
        c_in = 1'($urandom);
    endtask

    task automatic send(input logic [31:0] av, input logic [31:0] bv, input logic sv, input logic cv,
                        input logic [31:0] es, input logic ec, input logic eo, input bit push);
        int n = 0;
        exp_t x;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("issue_timeout", 64'(in_ready), 64'd1);
        a = av; b = bv; sub = sv; c_in = cv;
        in_valid = 1'b1;
        if (push) begin
            x.s = es; x.c = ec; x.o = eo;
            q.push_back(x);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        scramble();
    endtask

    // Counts edges from the accepting edge until out_valid is seen.
    task automatic wait_result();
        int lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!out_valid && lat < 40);
        chk("latency", 64'(lat), 64'(NB));
    endtask

    typedef struct {
        logic [31:0] a, b;
        logic        s, c;
        logic [31:0] es;
        logic        ec, eo;
    } vec_t;

    vec_t vecs[8] = '{
        '{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0},
        '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0},
        '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0},
        '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1},
        '{32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1, 32'h2345_678A, 1'b0, 1'b0},
        '{32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0007, 1'b1, 1'b0},
        '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1},
        '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1}
    };

    initial begin
        #200000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a = '0; b = '0; sub = 1'b0; c_in = 1'b0;
        out_ready = 1'b1;
        #12;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_sum", 64'(sum), 64'd0);
        chk("rst_c_out", 64'(c_out), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            send(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].c, vecs[i].es, vecs[i].ec, vecs[i].eo, 1'b1);
            wait_result();
        end

        // Backpressure: result held for 10 cycles while a new request waits.
        @(posedge clk);
        #1 out_ready = 1'b0;
        send(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b1);
        wait_result();
        a = 32'h4000_0000; b = 32'h4000_0000; sub = 1'b0; c_in = 1'b0;
        in_valid = 1'b1;
        e.s = 32'h8000_0000; e.c = 1'b0; e.o = 1'b1;
        q.push_back(e);
        repeat (10) begin
            chk("bp_hold", 64'({out_valid, in_ready, c_out, ovf, sum}),
                64'({1'b1, 1'b0, 1'b0, 1'b0, 32'h0001_0000}));
            @(negedge clk);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        chk("no_accept_on_consume", 64'(in_ready), 64'd0);
        @(negedge clk);
        chk("accept_after_consume", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        scramble();
        wait_result();

        // Reset after two bytes have been written; no result may appear.
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrun_rst_out_valid", 64'(out_valid), 64'd0);
        chk("midrun_rst_in_ready", 64'(in_ready), 64'd1);
        chk("midrun_rst_sum", 64'(sum), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b1);
        wait_result();
        @(negedge clk);
        @(negedge clk);

        chk("results_seen", 64'(got_n), 64'd11);
        chk("queue_empty", 64'(q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
